// File: rtl/matrix_pkg.sv
// Shared types and constants for the LED matrix scheduler: state encoding,
// glyph width, colour codes and an 8x8 font (row-major, MSB byte = top row).
package matrix_pkg;

    localparam int GLYPH_W = 64;

    localparam logic RED   = 1'b0;
    localparam logic GREEN = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHOW,
        ST_GAP
    } sched_state_e;

    localparam logic [GLYPH_W-1:0] char_0 = 64'h3C666E7666663C00;
    localparam logic [GLYPH_W-1:0] char_1 = 64'h183818181818_7E00;
    localparam logic [GLYPH_W-1:0] char_2 = 64'h3C66060C30607E00;
    localparam logic [GLYPH_W-1:0] char_3 = 64'h3C66061C06663C00;
    localparam logic [GLYPH_W-1:0] char_4 = 64'h0C1C3C6C7E0C0C00;
    localparam logic [GLYPH_W-1:0] char_5 = 64'h7E607C0606663C00;
    localparam logic [GLYPH_W-1:0] char_6 = 64'h3C607C6666663C00;
    localparam logic [GLYPH_W-1:0] char_7 = 64'h7E060C1830303000;
    localparam logic [GLYPH_W-1:0] char_8 = 64'h3C66663C66663C00;
    localparam logic [GLYPH_W-1:0] char_9 = 64'h3C66663E060C3800;

    localparam logic [GLYPH_W-1:0] char_A = 64'h183C66667E666600;
    localparam logic [GLYPH_W-1:0] char_B = 64'h7C66667C66667C00;
    localparam logic [GLYPH_W-1:0] char_C = 64'h3C66606060663C00;
    localparam logic [GLYPH_W-1:0] char_D = 64'h786C6666666C7800;
    localparam logic [GLYPH_W-1:0] char_E = 64'h7E60607C60607E00;
    localparam logic [GLYPH_W-1:0] char_F = 64'h7E60607C60606000;
    localparam logic [GLYPH_W-1:0] char_G = 64'h3C66606E66663E00;
    localparam logic [GLYPH_W-1:0] char_H = 64'h6666667E66666600;
    localparam logic [GLYPH_W-1:0] char_I = 64'h3C18181818183C00;
    localparam logic [GLYPH_W-1:0] char_J = 64'h1E0C0C0C6C6C3800;
    localparam logic [GLYPH_W-1:0] char_K = 64'h666C7870786C6600;
    localparam logic [GLYPH_W-1:0] char_L = 64'h6060606060607E00;
    localparam logic [GLYPH_W-1:0] char_M = 64'h63777F6B63636300;
    localparam logic [GLYPH_W-1:0] char_N = 64'h66767E7E6E666600;
    localparam logic [GLYPH_W-1:0] char_O = 64'h3C66666666663C00;
    localparam logic [GLYPH_W-1:0] char_P = 64'h7C66667C60606000;
    localparam logic [GLYPH_W-1:0] char_Q = 64'h3C6666666A6C3600;
    localparam logic [GLYPH_W-1:0] char_R = 64'h7C66667C786C6600;
    localparam logic [GLYPH_W-1:0] char_S = 64'h3C66603C06663C00;
    localparam logic [GLYPH_W-1:0] char_T = 64'h7E18181818181800;
    localparam logic [GLYPH_W-1:0] char_U = 64'h6666666666663C00;
    localparam logic [GLYPH_W-1:0] char_V = 64'h66666666663C1800;
    localparam logic [GLYPH_W-1:0] char_W = 64'h6363636B7F776300;
    localparam logic [GLYPH_W-1:0] char_X = 64'h66663C183C666600;
    localparam logic [GLYPH_W-1:0] char_Y = 64'h6666663C18181800;
    localparam logic [GLYPH_W-1:0] char_Z = 64'h7E060C1830607E00;

    // True when a count up to 'value' is representable in 'width' bits.
    function automatic bit cnt_fits(input longint value, input int width);
        return value < (longint'(1) << width);
    endfunction

endpackage

// File: rtl/matrix_scheduler_if.sv
// Requester/scanner bundle of the matrix scheduler: two request ports plus the
// scanner-facing char/color outputs and status.
interface matrix_scheduler_if;
    import matrix_pkg::*;

    logic               req0;
    logic [GLYPH_W-1:0] frame0;
    logic               color0;
    logic               ack0;
    logic               done0;

    logic               req1;
    logic [GLYPH_W-1:0] frame1;
    logic               color1;
    logic               ack1;
    logic               done1;

    logic [GLYPH_W-1:0] char;
    logic               color;
    logic               busy;
    logic               owner;

    modport master (
        output req0, frame0, color0, req1, frame1, color1,
        input  ack0, done0, ack1, done1, char, color, busy, owner
    );

    modport slave (
        input  req0, frame0, color0, req1, frame1, color1,
        output ack0, done0, ack1, done1, char, color, busy, owner
    );

endinterface

// File: rtl/matrix_sched_arb.sv
// Two-way request arbiter for the matrix scheduler. Fixed priority to port 0
// by default; round-robin with a registered rr_last when MATRIX_SCHED_RR_EN.
module matrix_sched_arb (
`ifdef MATRIX_SCHED_RR_EN
    input  logic clk,
    input  logic rst,
    input  logic grant_take,
`endif
    input  logic req0,
    input  logic req1,
    output logic grant_valid,
    output logic grant_id
);

`ifdef MATRIX_SCHED_RR_EN
    logic rr_last_q;
    logic rr_last_d;

    // On contention, the port that was not served last wins.
    always_comb begin
        grant_valid = req0 | req1;
        grant_id    = 1'b0;
        rr_last_d   = rr_last_q;
        if (req0 && req1) begin
            grant_id = ~rr_last_q;
        end else begin
            grant_id = req1;
        end
        if (grant_take) begin
            rr_last_d = grant_id;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last_q <= 1'b1;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`else
    always_comb begin
        grant_valid = req0 | req1;
        grant_id    = req1 & ~req0;
    end
`endif

endmodule

// File: rtl/matrix_scheduler.sv
// Time-shares the 8x8 matrix scanner between two frame requesters: grant,
// show for DWELL cycles, blank for GAP cycles, then pulse done. Optional
// round-robin arbitration via MATRIX_SCHED_RR_EN.
module matrix_scheduler
    import matrix_pkg::*;
#(
    parameter int                 DWELL      = 1000,
    parameter int                 GAP        = 100,
    parameter int                 CNT_W      = 16,
    parameter logic [GLYPH_W-1:0] IDLE_FRAME = '0
) (
    input  logic               clk,
    input  logic               rst,
    matrix_scheduler_if.slave  sched
);

    if (DWELL < 1 || GAP < 0) begin : g_bad_timing
        $error("matrix_scheduler: DWELL must be >= 1 and GAP >= 0");
    end

    if (!cnt_fits(longint'(DWELL) - 1, CNT_W) ||
        (GAP > 0 && !cnt_fits(longint'(GAP) - 1, CNT_W))) begin : g_bad_cnt_w
        $error("matrix_scheduler: CNT_W too small for DWELL/GAP");
    end

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP > 0) ? GAP - 1 : 0);

    sched_state_e       state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GLYPH_W-1:0] char_q, char_d;
    logic               color_q, color_d;
    logic               owner_q, owner_d;
    logic               busy_q, busy_d;
    logic               ack0_q, ack0_d;
    logic               ack1_q, ack1_d;
    logic               done0_q, done0_d;
    logic               done1_q, done1_d;

    logic grant_valid;
    logic grant_id;
    logic take_grant;

    assign take_grant = (state_q == ST_IDLE) && grant_valid;

    matrix_sched_arb u_arb (
`ifdef MATRIX_SCHED_RR_EN
        .clk         (clk),
        .rst         (rst),
        .grant_take  (take_grant),
`endif
        .req0        (sched.req0),
        .req1        (sched.req1),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // The done cycle is itself an IDLE cycle, so a pending request is granted
    // at its closing edge; the transition into IDLE never grants.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        char_d  = char_q;
        color_d = color_q;
        owner_d = owner_q;
        busy_d  = busy_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                char_d = IDLE_FRAME;
                if (take_grant) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                    owner_d = grant_id;
                    busy_d  = 1'b1;
                    char_d  = grant_id ? sched.frame1 : sched.frame0;
                    color_d = grant_id ? sched.color1 : sched.color0;
                    ack0_d  = ~grant_id;
                    ack1_d  = grant_id;
                end
            end

            ST_SHOW: begin
                if (cnt_q == DWELL_LAST) begin
                    cnt_d  = '0;
                    char_d = IDLE_FRAME;
                    if (GAP > 0) begin
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done0_d = ~owner_q;
                        done1_d = owner_q;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done0_d = ~owner_q;
                    done1_d = owner_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                char_d  = IDLE_FRAME;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Reset aborts any frame in flight without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            char_q  <= IDLE_FRAME;
            color_q <= RED;
            owner_q <= 1'b0;
            busy_q  <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            char_q  <= char_d;
            color_q <= color_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
        end
    end

    assign sched.char  = char_q;
    assign sched.color = color_q;
    assign sched.owner = owner_q;
    assign sched.busy  = busy_q;
    assign sched.ack0  = ack0_q;
    assign sched.ack1  = ack1_q;
    assign sched.done0 = done0_q;
    assign sched.done1 = done1_q;

endmodule

// File: tb/tb_matrix_scheduler.sv
// Bench for matrix_scheduler: a DWELL=4/GAP=2 instance and a DWELL=4/GAP=0
// instance, checked every cycle against a frame-timeline model.
`timescale 1ns/1ps
module tb_matrix_scheduler;
    import matrix_pkg::*;

    localparam int DWELL = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matrix_scheduler_if busA();
    matrix_scheduler_if busB();

    matrix_scheduler #(.DWELL(DWELL), .GAP(2), .CNT_W(4), .IDLE_FRAME(64'h0)) dutGap (
        .clk(clk), .rst(rst), .sched(busA));
    matrix_scheduler #(.DWELL(DWELL), .GAP(0), .CNT_W(4), .IDLE_FRAME(64'h0)) dutNoGap (
        .clk(clk), .rst(rst), .sched(busB));

    int cyc = 0;
    int passed = 0;
    int failed = 0;
    int total = 0;

    logic        reqS   [2][2];
    logic [63:0] frameS [2][2];
    logic        colorS [2][2];
    logic        expAck [2][2];

    bit          recValid [2];
    int          ackCyc   [2];
    int          idleFrom [2];
    logic        recOwner [2];
    logic [63:0] recFrame [2];
    logic        recColor [2];
`ifdef MATRIX_SCHED_RR_EN
    logic        rrLast   [2];
`endif

    function automatic int gapOf(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input int i, input int p, input logic r,
                                 input logic [63:0] f, input logic c);
        reqS[i][p] = r; frameS[i][p] = f; colorS[i][p] = c;
        if (i == 0 && p == 0) begin busA.req0 = r; busA.frame0 = f; busA.color0 = c; end
        else if (i == 0)      begin busA.req1 = r; busA.frame1 = f; busA.color1 = c; end
        else if (p == 0)      begin busB.req0 = r; busB.frame0 = f; busB.color0 = c; end
        else                  begin busB.req1 = r; busB.frame1 = f; busB.color1 = c; end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            recValid[i] = 1'b0;
            idleFrom[i] = cyc;
`ifdef MATRIX_SCHED_RR_EN
            rrLast[i] = 1'b1;
`endif
        end
    endtask

    // A frame granted at edge n is acked in cycle n, shown n..n+DWELL-1,
    // blanked for GAP cycles, and done is flagged in the following cycle.
    task automatic modelEdge();
        int p;
        if (rst) begin
            modelReset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            if (cyc - 1 >= idleFrom[i] && (reqS[i][0] || reqS[i][1])) begin
`ifdef MATRIX_SCHED_RR_EN
                if (reqS[i][0] && reqS[i][1]) p = rrLast[i] ? 0 : 1;
                else p = reqS[i][1] ? 1 : 0;
                rrLast[i] = (p == 1);
`else
                p = reqS[i][0] ? 0 : 1;
`endif
                recValid[i] = 1'b1;
                ackCyc[i]   = cyc;
                recOwner[i] = (p == 1);
                recFrame[i] = frameS[i][p];
                recColor[i] = colorS[i][p];
                idleFrom[i] = cyc + DWELL + gapOf(i);
            end
        end
    endtask

    task automatic checkOutput(input int i);
        logic [63:0] ch;
        logic col, bsy, own, a0, a1, d0, d1;
        logic [63:0] eCh;
        logic eCol, eBsy, eOwn;
        logic eAck [2];
        logic eDone [2];
        bit showing;
        string n;
        n = (i == 0) ? "gap2" : "gap0";
        if (i == 0) begin
            ch = busA.char; col = busA.color; bsy = busA.busy; own = busA.owner;
            a0 = busA.ack0; a1 = busA.ack1; d0 = busA.done0; d1 = busA.done1;
        end else begin
            ch = busB.char; col = busB.color; bsy = busB.busy; own = busB.owner;
            a0 = busB.ack0; a1 = busB.ack1; d0 = busB.done0; d1 = busB.done1;
        end
        eCh = 64'h0; eCol = 1'b0; eBsy = 1'b0; eOwn = 1'b0; showing = 1'b0;
        eAck[0] = 1'b0; eAck[1] = 1'b0; eDone[0] = 1'b0; eDone[1] = 1'b0;
        if (!rst && recValid[i]) begin
            if (cyc >= ackCyc[i] && cyc < ackCyc[i] + DWELL) begin
                showing = 1'b1;
                eCh = recFrame[i]; eCol = recColor[i]; eBsy = 1'b1; eOwn = recOwner[i];
                eAck[recOwner[i]] = (cyc == ackCyc[i]);
            end else if (cyc >= ackCyc[i] + DWELL && cyc < idleFrom[i]) begin
                eBsy = 1'b1; eOwn = recOwner[i];
            end else if (cyc == idleFrom[i]) begin
                eDone[recOwner[i]] = 1'b1;
            end
        end
        expAck[i][0] = eAck[0];
        expAck[i][1] = eAck[1];
        check({n, ".char"},  ch, eCh);
        check({n, ".busy"},  64'(bsy), 64'(eBsy));
        check({n, ".ack0"},  64'(a0),  64'(eAck[0]));
        check({n, ".ack1"},  64'(a1),  64'(eAck[1]));
        check({n, ".done0"}, 64'(d0),  64'(eDone[0]));
        check({n, ".done1"}, 64'(d1),  64'(eDone[1]));
        if (showing || rst) check({n, ".color"}, 64'(col), 64'(eCol));
        if (eBsy) check({n, ".owner"}, 64'(own), 64'(eOwn));
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        modelEdge();
        #1;
        checkOutput(0);
        checkOutput(1);
    endtask

    // Requesters drop req after ack unless holding; random mode also
    // re-requests, keeps some reqs for repeats and alters data after ack.
    task automatic runCycles(input int n, input bit rnd, input bit hold);
        logic keep;
        for (int k = 0; k < n; k++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                for (int p = 0; p < 2; p++) begin
                    if (reqS[i][p] && expAck[i][p]) begin
                        keep = hold || (rnd && $urandom_range(0, 3) == 0);
                        if (rnd)
                            applyStimulus(i, p, keep, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
                        else
                            applyStimulus(i, p, keep, frameS[i][p], colorS[i][p]);
                    end else if (rnd && !reqS[i][p] && $urandom_range(0, 4) == 0) begin
                        applyStimulus(i, p, 1'b1, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++)
            for (int p = 0; p < 2; p++)
                applyStimulus(i, p, 1'b0, 64'h0, 1'b0);
        modelReset();
        tick();
        tick();
        rst = 1'b0;
        runCycles(2, 1'b0, 1'b0);

        // Single request on the GAP=2 instance.
        applyStimulus(0, 0, 1'b1, 64'h00FEC2FCC2C2FC00, GREEN);
        tick();
        check("T2.ack0", 64'(busA.ack0), 64'h1);
        check("T2.char", busA.char, 64'h00FEC2FCC2C2FC00);
        applyStimulus(0, 0, 1'b0, 64'h0, RED);
        runCycles(9, 1'b0, 1'b0);

        // Simultaneous requests.
        applyStimulus(0, 0, 1'b1, char_A, RED);
        applyStimulus(0, 1, 1'b1, char_B, GREEN);
        runCycles(18, 1'b0, 1'b0);

        // Port 1 arrives while port 0 is showing.
        applyStimulus(0, 0, 1'b1, char_E, GREEN);
        runCycles(2, 1'b0, 1'b0);
        applyStimulus(0, 1, 1'b1, char_F, RED);
        runCycles(18, 1'b0, 1'b0);

        // Reset in the second SHOW cycle, request held through reset.
        applyStimulus(0, 0, 1'b1, char_C, RED);
        tick();
        applyStimulus(0, 0, 1'b0, char_C, RED);
        tick();
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput(0);
        checkOutput(1);
        applyStimulus(0, 0, 1'b1, char_D, GREEN);
        tick();
        tick();
        rst = 1'b0;
        runCycles(10, 1'b0, 1'b0);

        // GAP=0 instance with a held request repeats back to back.
        applyStimulus(1, 0, 1'b1, char_Z, GREEN);
        runCycles(14, 1'b0, 1'b1);
        applyStimulus(1, 0, 1'b0, char_Z, GREEN);
        runCycles(6, 1'b0, 1'b0);

        runCycles(400, 1'b1, 1'b0);

        for (int i = 0; i < 2; i++)
            for (int p = 0; p < 2; p++)
                applyStimulus(i, p, 1'b0, 64'h0, 1'b0);
        runCycles(12, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
